reduce_egress: RTL and testbench
================================

REDUCE_EGRESS -- requirements
Module: reduce_egress

Interface
REQ-001 Parameter rank_x, default 3'b0, X coordinate of this node.
REQ-002 Parameter rank_y, default 3'b0, Y coordinate of this node.
REQ-003 Parameter rank_z, default 3'b0, Z coordinate of this node.
REQ-004 Parameter FlitWidth, default 73, flit width: valid bit 72, dst_z 71-69, dst_y 68-66, dst_x 65-63, remaining fields carried opaque.
REQ-005 Parameter FifoDepth, default 4, egress queue entries (power of two, at least 2).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 in_flit  input  FlitWidth  completed reduction packet from the reduction unit.
REQ-009 in_valid  input  1  in_flit valid this cycle (the reduction unit's done pulse).
REQ-010 in_ready  output  1  queue can accept a flit this cycle.
REQ-011 out_flit  output  FlitWidth  flit presented to the router.
REQ-012 out_port  output  3  next-hop port for out_flit.
REQ-013 out_valid  output  1  out_flit/out_port valid.
REQ-014 out_ready  input  1  router accepts out_flit this cycle.
REQ-015 fifo_count  output  3  occupied queue entries, 0..FifoDepth.
REQ-016 drop_count  output  8  flits lost to overflow, saturating.

Function
REQ-017 in_ready SHALL be 1 iff fifo_count < FifoDepth; a pop in the same cycle SHALL NOT raise in_ready.
REQ-018 Push: in_valid=1 with in_ready=1 and in_flit[72]=1 SHALL write the flit at the tail on that edge.
REQ-019 A flit with in_flit[72]=0 SHALL be discarded and SHALL NOT count as a drop.
REQ-020 in_valid=1 with in_flit[72]=1 and in_ready=0 SHALL discard the flit and increment drop_count; drop_count SHALL hold at 255.
REQ-021 The output stage SHALL be a two-state machine, IDLE (out_valid=0) and SEND (out_valid=1).
REQ-022 In IDLE with fifo_count>0, the head SHALL load into the output register, pop, and move to SEND on that edge.
REQ-023 In SEND with out_ready=1 and fifo_count>0, the next head SHALL load and pop on the same edge, staying in SEND (back-to-back, no bubble).
REQ-024 In SEND with out_ready=1 and fifo_count=0, the machine SHALL return to IDLE.
REQ-025 In SEND with out_ready=0, out_flit, out_port and out_valid SHALL hold stable.
REQ-026 Latency: a flit pushed at edge N into an empty queue with the output stage in IDLE SHALL have out_valid=1 after edge N+1.
REQ-027 Simultaneous push and pop SHALL be legal; fifo_count SHALL be unchanged.
REQ-028 Head and tail pointers SHALL wrap modulo FifoDepth, and order SHALL be strictly FIFO.
REQ-029 out_port SHALL be computed from the flit at load time using dimension-ordered routing, X then Y then Z, on a non-wrapping mesh.
REQ-030 out_port encoding: dst_x>rank_x: 0 (X+); dst_x<rank_x: 1 (X-); otherwise dst_y>rank_y: 2, dst_y<rank_y: 3; otherwise dst_z>rank_z: 4, dst_z<rank_z: 5; all equal: 6 (LOCAL). Value 7 SHALL never be driven.
REQ-031 Coordinate comparisons SHALL be unsigned 3-bit.
REQ-032 out_flit SHALL equal the queued flit bit-for-bit.

Reset
REQ-033 When rst=0, regardless of clk: out_valid=0, out_flit=0, out_port=0, fifo_count=0, drop_count=0, pointers=0, state=IDLE, in_ready=1.
REQ-034 Reset asserted mid-transfer SHALL discard all queued and presented flits; no flit SHALL appear after release unless pushed after release.
REQ-035 The first push SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-036 Scenario: rank=(0,0,0); push dst=(3,0,0), then (0,2,0), then (0,0,5), then (0,0,0) with out_ready=1 -> out_port sequence 0,2,4,6, flits unchanged, one per cycle.
REQ-037 Scenario: rank=(4,4,4); push dst=(1,7,7) -> out_port=1. Push dst=(4,2,7) -> out_port=3. Push dst=(4,4,0) -> out_port=5.
REQ-038 Scenario: out_ready=0; push 6 valid flits on consecutive cycles -> queue holds 4, output register holds 1, drop_count=1, in_ready=0 while fifo_count=4, output held stable.
REQ-039 Scenario: continuous push and pop with out_ready=1 for 20 cycles -> fifo_count constant, no drops, order preserved across pointer wrap.
REQ-040 Scenario: push with in_flit[72]=0 -> no enqueue, drop_count unchanged.
REQ-041 Scenario: assert rst between clock edges while in SEND with 3 flits queued -> outputs cleared immediately; after release, out_valid stays 0 until a new push.

Source files
------------

// File: rtl/reduce_egress.sv
// rtl/reduce_egress.sv - Egress queue and dimension-ordered output stage for completed reduction packets
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-low reset
//   in_flit    in   FlitWidth  completed reduction packet
//   in_valid   in   1          in_flit valid (reduction unit done pulse)
//   in_ready   out  1          queue has a free entry
//   out_flit   out  FlitWidth  flit presented to the router
//   out_port   out  3          next-hop port for out_flit
//   out_valid  out  1          out_flit/out_port valid
//   out_ready  in   1          router accepts out_flit
//   fifo_count out  3          occupied queue entries
//   drop_count out  8          flits lost to overflow, saturating
module reduce_egress #(
    parameter logic [2:0] rank_x    = 3'b0,
    parameter logic [2:0] rank_y    = 3'b0,
    parameter logic [2:0] rank_z    = 3'b0,
    parameter int         FlitWidth = 73,
    parameter int         FifoDepth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FlitWidth-1:0] in_flit,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FlitWidth-1:0] out_flit,
    output logic [2:0]           out_port,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           fifo_count,
    output logic [7:0]           drop_count
);

    localparam int AddrWidth  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CountWidth = $clog2(FifoDepth + 1);
    localparam logic [CountWidth-1:0] DepthCount = CountWidth'(FifoDepth);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [FlitWidth-1:0]  mem [FifoDepth];
    logic [AddrWidth-1:0]  wr_ptr;
    logic [AddrWidth-1:0]  rd_ptr;
    logic [CountWidth-1:0] count;
    logic [7:0]            drops;
    logic                  push;
    logic                  drop;
    logic                  load;
    logic [FlitWidth-1:0]  head;

    // Dimension-ordered routing on a non-wrapping mesh: resolve X, then Y, then Z.
    function automatic logic [2:0] route(input logic [8:0] dst);
        logic [2:0] dz;
        logic [2:0] dy;
        logic [2:0] dx;
        dz = dst[8:6];
        dy = dst[5:3];
        dx = dst[2:0];
        if (dx > rank_x)      route = 3'd0;
        else if (dx < rank_x) route = 3'd1;
        else if (dy > rank_y) route = 3'd2;
        else if (dy < rank_y) route = 3'd3;
        else if (dz > rank_z) route = 3'd4;
        else if (dz < rank_z) route = 3'd5;
        else                  route = 3'd6;
    endfunction

    // in_ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign in_ready   = (count < DepthCount);
    assign push       = in_valid && in_flit[FlitWidth-1] && in_ready;
    assign drop       = in_valid && in_flit[FlitWidth-1] && !in_ready;
    assign head       = mem[rd_ptr];
    assign out_valid  = (state_q == SEND);
    assign fifo_count = 3'(count);
    assign drop_count = drops;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (count != '0) load = 1'b1;
                    else             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Storage is not reset; only the pointers and count define what is queued.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_flit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AddrWidth'(1);
            if (load) rd_ptr <= rd_ptr + AddrWidth'(1);
            case ({push, load})
                2'b10:   count <= count + CountWidth'(1);
                2'b01:   count <= count - CountWidth'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drops <= '0;
        end else if (drop && drops != 8'hFF) begin
            drops <= drops + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_flit <= '0;
            out_port <= '0;
        end else if (load) begin
            out_flit <= head;
            out_port <= route(head[71:63]);
        end
    end

endmodule

// File: tb/tb_reduce_egress.sv
// tb/tb_reduce_egress.sv - Scoreboard testbench for reduce_egress
module tb_reduce_egress;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [72:0] in_flit_a;
    logic        in_valid_a;
    logic        in_ready_a;
    logic [72:0] out_flit_a;
    logic [2:0]  out_port_a;
    logic        out_valid_a;
    logic        out_ready_a;
    logic [2:0]  fifo_count_a;
    logic [7:0]  drop_count_a;

    logic [72:0] in_flit_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [72:0] out_flit_b;
    logic [2:0]  out_port_b;
    logic        out_valid_b;
    logic        out_ready_b;
    logic [2:0]  fifo_count_b;
    logic [7:0]  drop_count_b;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [75:0] q_a[$];
    logic [75:0] q_b[$];

    reduce_egress #(.rank_x(3'd0), .rank_y(3'd0), .rank_z(3'd0), .FlitWidth(73), .FifoDepth(4)) dut (
        .clk(clk), .rst(rst),
        .in_flit(in_flit_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_flit(out_flit_a), .out_port(out_port_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .fifo_count(fifo_count_a), .drop_count(drop_count_a)
    );

    reduce_egress #(.rank_x(3'd4), .rank_y(3'd4), .rank_z(3'd4), .FlitWidth(73), .FifoDepth(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_flit(in_flit_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_flit(out_flit_b), .out_port(out_port_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .fifo_count(fifo_count_b), .drop_count(drop_count_b)
    );

    function automatic logic [72:0] mk(input logic v, input logic [2:0] x, input logic [2:0] y,
                                       input logic [2:0] z, input logic [62:0] pl);
        return {v, z, y, x, pl};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [72:0] f, input logic [2:0] p, input bit accepted);
        in_flit_a  = f;
        in_valid_a = 1'b1;
        if (accepted) q_a.push_back({p, f});
        tick();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q_a.size() != 0 || out_valid_a || q_b.size() != 0 || out_valid_b) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_within_budget", {79'd0, n < budget}, 80'd1);
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        logic [75:0] e;
        if (rst && out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out_a: actual flit %0h required none", out_flit_a);
            end else begin
                e = q_a.pop_front();
                chk("out_flit_a", {7'd0, out_flit_a}, {7'd0, e[72:0]});
                chk("out_port_a", {77'd0, out_port_a}, {77'd0, e[75:73]});
            end
        end
        if (rst && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out_b: actual flit %0h required none", out_flit_b);
            end else begin
                e = q_b.pop_front();
                chk("out_flit_b", {7'd0, out_flit_b}, {7'd0, e[72:0]});
                chk("out_port_b", {77'd0, out_port_b}, {77'd0, e[75:73]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [72:0] f0;
        logic [72:0] fa [4];
        logic [2:0]  pa [4];
        logic [72:0] fb [3];
        logic [2:0]  pb [3];

        rst = 1'b0;
        in_flit_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        in_flit_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {79'd0, out_valid_a}, 80'd0);
        chk("rst_out_flit", {7'd0, out_flit_a}, 80'd0);
        chk("rst_out_port", {77'd0, out_port_a}, 80'd0);
        chk("rst_fifo_count", {77'd0, fifo_count_a}, 80'd0);
        chk("rst_drop_count", {72'd0, drop_count_a}, 80'd0);
        chk("rst_in_ready", {79'd0, in_ready_a}, 80'd1);
        @(negedge clk);
        rst = 1'b1;

        // Routing: rank (0,0,0) on dut, rank (4,4,4) on dut_b; first push on first edge after release.
        fa[0] = mk(1'b1, 3'd3, 3'd0, 3'd0, 63'h11); pa[0] = 3'd0;
        fa[1] = mk(1'b1, 3'd0, 3'd2, 3'd0, 63'h22); pa[1] = 3'd2;
        fa[2] = mk(1'b1, 3'd0, 3'd0, 3'd5, 63'h33); pa[2] = 3'd4;
        fa[3] = mk(1'b1, 3'd0, 3'd0, 3'd0, 63'h44); pa[3] = 3'd6;
        fb[0] = mk(1'b1, 3'd1, 3'd7, 3'd7, 63'h55); pb[0] = 3'd1;
        fb[1] = mk(1'b1, 3'd4, 3'd2, 3'd7, 63'h66); pb[1] = 3'd3;
        fb[2] = mk(1'b1, 3'd4, 3'd4, 3'd0, 63'h77); pb[2] = 3'd5;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                in_flit_b  = fb[i];
                in_valid_b = 1'b1;
                q_b.push_back({pb[i], fb[i]});
            end else begin
                in_valid_b = 1'b0;
            end
            send_a(fa[i], pa[i], 1'b1);
            if (i == 0) chk("first_edge_push", {77'd0, fifo_count_a}, 80'd1);
            else        chk("back_to_back_valid", {79'd0, out_valid_a}, 80'd1);
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        drain(20);

        // Invalid flit is discarded without counting as a drop.
        send_a(mk(1'b0, 3'd1, 3'd0, 3'd0, 63'h99), 3'd0, 1'b0);
        in_valid_a = 1'b0;
        tick();
        chk("invalid_no_enqueue", {77'd0, fifo_count_a}, 80'd0);
        chk("invalid_no_output", {79'd0, out_valid_a}, 80'd0);
        chk("invalid_no_drop", {72'd0, drop_count_a}, 80'd0);

        // Continuous push and pop across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            send_a(mk(1'b1, 3'd0, 3'd0, 3'd1, 63'(200 + i)), 3'd4, 1'b1);
            if (i >= 1) chk("stream_fifo_count", {77'd0, fifo_count_a}, 80'd1);
        end
        in_valid_a = 1'b0;
        drain(20);
        chk("stream_no_drop", {72'd0, drop_count_a}, 80'd0);

        // Overflow with the router stalled.
        out_ready_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_a(mk(1'b1, 3'd0, 3'd3, 3'd0, 63'(100 + i)), 3'd2, i < 5);
            if (i == 4) begin
                chk("full_in_ready", {79'd0, in_ready_a}, 80'd0);
                chk("full_fifo_count", {77'd0, fifo_count_a}, 80'd4);
            end
        end
        in_valid_a = 1'b0;
        chk("overflow_drop", {72'd0, drop_count_a}, 80'd1);
        chk("overflow_fifo_count", {77'd0, fifo_count_a}, 80'd4);
        f0 = mk(1'b1, 3'd0, 3'd3, 3'd0, 63'd100);
        for (int i = 0; i < 3; i++) begin
            chk("hold_out_flit", {7'd0, out_flit_a}, {7'd0, f0});
            chk("hold_out_port", {77'd0, out_port_a}, 80'd2);
            chk("hold_out_valid", {79'd0, out_valid_a}, 80'd1);
            tick();
        end
        out_ready_a = 1'b1;
        drain(20);
        chk("drop_after_drain", {72'd0, drop_count_a}, 80'd1);

        // Drop counter saturation.
        out_ready_a = 1'b0;
        for (int i = 0; i < 305; i++) begin
            send_a(mk(1'b1, 3'd0, 3'd0, 3'd6, 63'(1000 + i)), 3'd4, i < 5);
        end
        in_valid_a = 1'b0;
        chk("drop_saturate", {72'd0, drop_count_a}, 80'd255);
        chk("saturate_fifo_count", {77'd0, fifo_count_a}, 80'd4);
        out_ready_a = 1'b1;
        drain(20);

        // Reset between edges while sending with three flits queued.
        out_ready_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_a(mk(1'b1, 3'd5, 3'd0, 3'd0, 63'(2000 + i)), 3'd0, 1'b1);
        end
        in_valid_a = 1'b0;
        chk("pre_reset_fifo_count", {77'd0, fifo_count_a}, 80'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_out_valid", {79'd0, out_valid_a}, 80'd0);
        chk("async_out_flit", {7'd0, out_flit_a}, 80'd0);
        chk("async_out_port", {77'd0, out_port_a}, 80'd0);
        chk("async_fifo_count", {77'd0, fifo_count_a}, 80'd0);
        chk("async_drop_count", {72'd0, drop_count_a}, 80'd0);
        chk("async_in_ready", {79'd0, in_ready_a}, 80'd1);
        q_a.delete();
        @(negedge clk);
        #1;
        rst = 1'b1;
        out_ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_idle", {79'd0, out_valid_a}, 80'd0);
        end
        send_a(mk(1'b1, 3'd0, 3'd0, 3'd0, 63'h3AB), 3'd6, 1'b1);
        in_valid_a = 1'b0;
        chk("post_reset_push", {77'd0, fifo_count_a}, 80'd1);
        tick();
        chk("post_reset_latency", {79'd0, out_valid_a}, 80'd1);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
